// File: rtl/yuv422to444.sv
// 4:2:2 to 4:4:4 horizontal chroma upsampler: each 4-pixel input beat becomes two 2-pixel output beats.
// Define YUV422TO444_CHROMA_INTERP_EN for interpolated odd-pixel chroma; otherwise chroma is replicated.
module yuv422to444 (
  input  logic        clk,
  input  logic        rst,
  input  logic        src_t_valid,
  output logic        src_t_ready,
  input  logic [63:0] src_t_data,
  input  logic        src_t_last,
  output logic        dst_t_valid,
  input  logic        dst_t_ready,
  output logic [63:0] dst_t_data,
  output logic        dst_t_last,
  output logic [7:0]  dst_t_keep
);

`ifdef YUV422TO444_CHROMA_INTERP_EN
  localparam logic INTERP = 1'b1;
  typedef enum logic [1:0] {EMPTY, SEND_A, WAIT_NEXT, SEND_B} state_t;
`else
  localparam logic INTERP = 1'b0;
  typedef enum logic [1:0] {EMPTY, SEND_A, SEND_B} state_t;
`endif

  state_t      state_reg, state_next;
  logic [63:0] cur_data_reg;
  logic        cur_last_reg;
  logic        dst_valid_reg;
  logic [63:0] dst_data_reg;
  logic        dst_last_reg;
`ifdef YUV422TO444_CHROMA_INTERP_EN
  logic        nxt_valid_reg;
  logic [63:0] nxt_data_reg;
  logic        nxt_last_reg;
`endif

  function automatic logic [7:0] avg(input logic [7:0] a, input logic [7:0] b);
    return 8'(({1'b0, a} + {1'b0, b} + 9'd1) >> 1);
  endfunction

  // pair layout is {V, Yodd, U, Yeven}; u_nb/v_nb are the chroma of the following pair
  function automatic logic [63:0] expand(input logic [31:0] pair, input logic [7:0] u_nb,
                                         input logic [7:0] v_nb, input logic blend);
    logic [7:0] u_odd;
    logic [7:0] v_odd;
    u_odd = blend ? avg(pair[15:8], u_nb) : pair[15:8];
    v_odd = blend ? avg(pair[31:24], v_nb) : pair[31:24];
    return {8'h00, pair[23:16], u_odd, v_odd, 8'h00, pair[7:0], pair[15:8], pair[31:24]};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY:  if (src_t_valid) state_next = SEND_A;
      SEND_A: begin
        if (dst_t_ready) begin
`ifdef YUV422TO444_CHROMA_INTERP_EN
          state_next = cur_last_reg ? SEND_B : WAIT_NEXT;
`else
          state_next = SEND_B;
`endif
        end
      end
`ifdef YUV422TO444_CHROMA_INTERP_EN
      WAIT_NEXT: if (src_t_valid) state_next = SEND_B;
`endif
      SEND_B: begin
        if (dst_t_ready) begin
`ifdef YUV422TO444_CHROMA_INTERP_EN
          state_next = nxt_valid_reg ? SEND_A : EMPTY;
`else
          state_next = EMPTY;
`endif
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_comb begin
    src_t_ready = (state_reg == EMPTY);
`ifdef YUV422TO444_CHROMA_INTERP_EN
    if (state_reg == WAIT_NEXT) src_t_ready = 1'b1;
`endif
    dst_t_valid = dst_valid_reg;
    dst_t_data  = dst_data_reg;
    dst_t_last  = dst_last_reg;
    dst_t_keep  = 8'hff;
  end

  // Output beats are built one edge ahead so data/valid/last leave straight from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_data_reg  <= '0;
      cur_last_reg  <= 1'b0;
      dst_valid_reg <= 1'b0;
      dst_data_reg  <= '0;
      dst_last_reg  <= 1'b0;
`ifdef YUV422TO444_CHROMA_INTERP_EN
      nxt_valid_reg <= 1'b0;
      nxt_data_reg  <= '0;
      nxt_last_reg  <= 1'b0;
`endif
    end else begin
      case (state_reg)
        EMPTY: begin
          if (src_t_valid) begin
            cur_data_reg  <= src_t_data;
            cur_last_reg  <= src_t_last;
            dst_valid_reg <= 1'b1;
            dst_data_reg  <= expand(src_t_data[31:0], src_t_data[47:40], src_t_data[63:56], INTERP);
            dst_last_reg  <= 1'b0;
          end
        end
        SEND_A: begin
          if (dst_t_ready) begin
            if (INTERP && !cur_last_reg) begin
              dst_valid_reg <= 1'b0;
            end else begin
              dst_valid_reg <= 1'b1;
              dst_data_reg  <= expand(cur_data_reg[63:32], cur_data_reg[47:40],
                                      cur_data_reg[63:56], 1'b0);
              dst_last_reg  <= cur_last_reg;
            end
          end
        end
`ifdef YUV422TO444_CHROMA_INTERP_EN
        WAIT_NEXT: begin
          if (src_t_valid) begin
            nxt_valid_reg <= 1'b1;
            nxt_data_reg  <= src_t_data;
            nxt_last_reg  <= src_t_last;
            dst_valid_reg <= 1'b1;
            dst_data_reg  <= expand(cur_data_reg[63:32], src_t_data[15:8], src_t_data[31:24],
                                    !cur_last_reg);
            dst_last_reg  <= cur_last_reg;
          end
        end
`endif
        SEND_B: begin
          if (dst_t_ready) begin
`ifdef YUV422TO444_CHROMA_INTERP_EN
            if (nxt_valid_reg) begin
              cur_data_reg  <= nxt_data_reg;
              cur_last_reg  <= nxt_last_reg;
              nxt_valid_reg <= 1'b0;
              dst_valid_reg <= 1'b1;
              dst_data_reg  <= expand(nxt_data_reg[31:0], nxt_data_reg[47:40],
                                      nxt_data_reg[63:56], 1'b1);
              dst_last_reg  <= 1'b0;
            end else begin
              dst_valid_reg <= 1'b0;
            end
`else
            dst_valid_reg <= 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_yuv422to444.sv
// Self-checking bench for yuv422to444: directed vectors plus random lines against a pixel-level model.
// Follows the YUV422TO444_CHROMA_INTERP_EN setting of the build.
module tb_yuv422to444;

`ifdef YUV422TO444_CHROMA_INTERP_EN
  localparam bit INTERP = 1'b1;
`else
  localparam bit INTERP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        src_t_valid;
  logic        src_t_ready;
  logic [63:0] src_t_data;
  logic        src_t_last;
  logic        dst_t_valid;
  logic        dst_t_ready;
  logic [63:0] dst_t_data;
  logic        dst_t_last;
  logic [7:0]  dst_t_keep;

  int compared = 0;
  int mismatched = 0;

  logic [63:0] line_q[$];
  logic [63:0] exp_data_q[$];
  logic        exp_last_q[$];

  yuv422to444 dut (
    .clk(clk), .rst(rst),
    .src_t_valid(src_t_valid), .src_t_ready(src_t_ready),
    .src_t_data(src_t_data), .src_t_last(src_t_last),
    .dst_t_valid(dst_t_valid), .dst_t_ready(dst_t_ready),
    .dst_t_data(dst_t_data), .dst_t_last(dst_t_last), .dst_t_keep(dst_t_keep)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic void clear_line();
    line_q.delete();
    exp_data_q.delete();
    exp_last_q.delete();
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Pixel-level reference: split the line into luma samples and per-pair chroma,
  // then derive each odd pixel's chroma from its own pair and the next pair on the line.
  function automatic void model_line();
    logic [7:0] y[$];
    logic [7:0] u[$];
    logic [7:0] v[$];
    int np;
    for (int b = 0; b < line_q.size(); b++) begin
      for (int h = 0; h < 2; h++) begin
        logic [63:0] beat;
        logic [31:0] w;
        beat = line_q[b];
        w = beat[32*h +: 32];
        y.push_back(w[7:0]);
        y.push_back(w[23:16]);
        u.push_back(w[15:8]);
        v.push_back(w[31:24]);
      end
    end
    np = u.size();
    for (int p = 0; p < np; p++) begin
      int uo, vo;
      if (INTERP && (p + 1 < np)) begin
        uo = (int'(u[p]) + int'(u[p+1]) + 1) / 2;
        vo = (int'(v[p]) + int'(v[p+1]) + 1) / 2;
      end else begin
        uo = int'(u[p]);
        vo = int'(v[p]);
      end
      exp_data_q.push_back({8'h00, y[2*p+1], 8'(uo), 8'(vo), 8'h00, y[2*p], u[p], v[p]});
      exp_last_q.push_back(p == np - 1);
    end
  endfunction

  // Streams line_q in and checks every output handshake against the expected queues.
  // ready_mode: 0 = always ready, 1 = toggle each cycle, 2 = random.
  task automatic run_line(input string name, input int ready_mode, input int gap_pct);
    int in_idx = 0;
    int out_idx = 0;
    int n_in = line_q.size();
    int n_out = exp_data_q.size();
    int cyc = 0;
    bit stalled = 0;
    bit expect_valid = 0;
    bit first_pending = 0;
    bit tog = 1'b1;
    bit acc;
    logic [63:0] held_data = '0;
    logic held_last = 1'b0;
    while (out_idx < n_out && cyc < 3000) begin
      src_t_valid = (in_idx < n_in) && (int'($urandom_range(99)) >= gap_pct);
      src_t_data  = src_t_valid ? line_q[in_idx] : rnd64();
      src_t_last  = src_t_valid && (in_idx == n_in - 1);
      case (ready_mode)
        0: dst_t_ready = 1'b1;
        1: dst_t_ready = tog;
        default: dst_t_ready = ($urandom_range(99) < 70);
      endcase
      tog = ~tog;
      @(negedge clk);
      check({name, " src_ready_excl"}, 64'(src_t_ready && dst_t_valid), 64'd0);
      if (expect_valid) check({name, " no_bubble"}, 64'(dst_t_valid), 64'd1);
      if (first_pending) check({name, " a_latency"}, 64'(dst_t_valid), 64'd1);
      if (stalled) begin
        check({name, " stall_data"}, dst_t_data, held_data);
        check({name, " stall_last"}, 64'(dst_t_last), 64'(held_last));
      end
      if (dst_t_valid && dst_t_ready) begin
        check($sformatf("%s beat%0d data", name, out_idx), dst_t_data, exp_data_q[out_idx]);
        check($sformatf("%s beat%0d last", name, out_idx), 64'(dst_t_last), 64'(exp_last_q[out_idx]));
        check($sformatf("%s beat%0d keep", name, out_idx), 64'(dst_t_keep), 64'hff);
        $display("%s out beat %0d data=%h last=%0d", name, out_idx, dst_t_data, dst_t_last);
        expect_valid = (out_idx != n_out - 1) && (INTERP ? (out_idx % 2 == 1) : (out_idx % 2 == 0));
        out_idx++;
      end else begin
        expect_valid = 1'b0;
      end
      stalled   = dst_t_valid && !dst_t_ready;
      held_data = dst_t_data;
      held_last = dst_t_last;
      acc = src_t_valid && src_t_ready;
      first_pending = acc && (in_idx == 0);
      if (acc) in_idx++;
      @(posedge clk);
      #1;
      cyc++;
    end
    src_t_valid = 1'b0;
    dst_t_ready = 1'b1;
    check({name, " drained"}, 64'(out_idx), 64'(n_out));
    check({name, " consumed"}, 64'(in_idx), 64'(n_in));
  endtask

  initial begin
    rst = 1'b1;
    src_t_valid = 1'b0;
    src_t_data = '0;
    src_t_last = 1'b0;
    dst_t_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset dst_valid", 64'(dst_t_valid), 64'd0);
    check("reset dst_last", 64'(dst_t_last), 64'd0);
    check("reset dst_data", dst_t_data, 64'd0);
    check("reset src_ready", 64'(src_t_ready), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed vector: Y0=10 U0=100 Y1=20 V0=200 Y2=30 U1=110 Y3=40 V1=210
    clear_line();
    if (INTERP) begin
      line_q.push_back(64'hD2286E1E_C814640A);
      line_q.push_back(64'hE6048203_DD027901);
      exp_data_q = '{64'h001469CD_000A64C8, 64'h002874D8_001E6ED2,
                     64'h00027EE2_000179DD, 64'h000482E6_000382E6};
      exp_last_q = '{1'b0, 1'b0, 1'b0, 1'b1};
    end else begin
      line_q.push_back(64'hD2286E1E_C814640A);
      exp_data_q = '{64'h001464C8_000A64C8, 64'h00286ED2_001E6ED2};
      exp_last_q = '{1'b0, 1'b1};
    end
    run_line("directed", 0, 0);

    // Rounding edges: U0=255,U1=254 then U0=0,U1=1
    clear_line();
    line_q.push_back(64'h0000FE00_0000FF00);
    exp_data_q = '{64'h0000FF00_0000FF00, 64'h0000FE00_0000FE00};
    exp_last_q = '{1'b0, 1'b1};
    run_line("round_hi", 0, 0);
    clear_line();
    line_q.push_back(64'h00000100_00000000);
    exp_data_q = '{INTERP ? 64'h00000100_00000000 : 64'h0, 64'h00000100_00000100};
    exp_last_q = '{1'b0, 1'b1};
    run_line("round_lo", 0, 0);

    // 7-beat line with source valid held high
    clear_line();
    for (int i = 0; i < 7; i++) line_q.push_back(rnd64());
    model_line();
    run_line("line7", 0, 0);

    // Backpressure toggling every cycle over a 3-beat line
    clear_line();
    for (int i = 0; i < 3; i++) line_q.push_back(rnd64());
    model_line();
    run_line("bp_toggle", 1, 0);

    // Reset pulse after the A beat of a non-last beat has been taken
    src_t_valid = 1'b1;
    src_t_data  = rnd64();
    src_t_last  = 1'b0;
    dst_t_ready = 1'b1;
    @(posedge clk);
    #1;
    src_t_valid = 1'b0;
    @(negedge clk);
    check("rst_test a_valid", 64'(dst_t_valid), 64'd1);
    @(posedge clk);
    #1;
    dst_t_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    dst_t_ready = 1'b1;
    @(negedge clk);
    check("rst_test dst_valid", 64'(dst_t_valid), 64'd0);
    check("rst_test src_ready", 64'(src_t_ready), 64'd1);
    @(posedge clk);
    #1;
    clear_line();
    line_q.push_back(rnd64());
    model_line();
    run_line("after_rst", 0, 0);

    // Random lines with source gaps and random backpressure
    for (int l = 0; l < 20; l++) begin
      int len;
      len = int'($urandom_range(1, 6));
      clear_line();
      for (int i = 0; i < len; i++) line_q.push_back(rnd64());
      model_line();
      run_line($sformatf("rand%0d", l), 2, 30);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
